// File: rtl/usb_bus_arb.sv
// Two-master round-robin arbiter for the USB core bus; optional ack watchdog under USB_BUS_ARB_WATCHDOG_EN.
// Latency: s_cyc follows a seen request by 1 cycle; acks and read data pass through combinationally.
// Backpressure: a losing master holds cyc until granted; the owner keeps the bus until s_ack, abort or watchdog.
module usb_bus_arb #(
  parameter int TIMEOUT = 63,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [15:0]       m0_din,
  output logic [15:0]       m0_dout,
  input  logic              m0_cyc,
  input  logic              m0_we,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [15:0]       m1_din,
  output logic [15:0]       m1_dout,
  input  logic              m1_cyc,
  input  logic              m1_we,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] s_addr,
  output logic [15:0]       s_din,
  input  logic [15:0]       s_dout,
  output logic              s_cyc,
  output logic              s_we,
  input  logic              s_ack,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

  state_t state_q, state_d;
  logic   last_m1_q, last_m1_d;
  logic   own0, own1, wd_expire;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_timeout_check
    $error("usb_bus_arb: TIMEOUT must be within 2..255");
  end

`ifdef USB_BUS_ARB_WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

  logic [7:0] wd_cnt_q, wd_cnt_d;

  // A same-cycle s_ack always beats expiry.
  assign wd_expire = (own0 || own1) && !s_ack && (wd_cnt_q == WD_LAST);

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!(own0 || own1))
      wd_cnt_d = '0;
    else if (!s_ack)
      wd_cnt_d = wd_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      wd_cnt_q <= '0;
    else
      wd_cnt_q <= wd_cnt_d;
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
    end
  end

  // Round robin: on contention the master not granted last wins.
  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    case (state_q)
      IDLE: begin
        if (m0_cyc && (!m1_cyc || last_m1_q)) begin
          state_d   = OWN0;
          last_m1_d = 1'b0;
        end else if (m1_cyc) begin
          state_d   = OWN1;
          last_m1_d = 1'b1;
        end
      end
      OWN0: if (s_ack || !m0_cyc || wd_expire) state_d = GAP;
      OWN1: if (s_ack || !m1_cyc || wd_expire) state_d = GAP;
      GAP:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Everything is forced quiet while rst is high, even if the state has not yet been cleared.
  always_comb begin
    s_addr  = '0;
    s_din   = '0;
    s_we    = 1'b0;
    s_cyc   = 1'b0;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    m0_err  = 1'b0;
    m1_err  = 1'b0;
    m0_dout = '0;
    m1_dout = '0;
    grant   = 2'b00;
    if (!rst) begin
      if (own0) begin
        grant   = 2'b01;
        s_addr  = m0_addr;
        s_din   = m0_din;
        s_we    = m0_we;
        s_cyc   = m0_cyc;
        m0_ack  = s_ack | wd_expire;
        m0_err  = wd_expire;
        m0_dout = s_ack ? s_dout : '0;
      end else if (own1) begin
        grant   = 2'b10;
        s_addr  = m1_addr;
        s_din   = m1_din;
        s_we    = m1_we;
        s_cyc   = m1_cyc;
        m1_ack  = s_ack | wd_expire;
        m1_err  = wd_expire;
        m1_dout = s_ack ? s_dout : '0;
      end
    end
  end

endmodule

// File: tb/tb_usb_bus_arb.sv
// Self-checking bench for usb_bus_arb: scripted masters/slave, ack scoreboard checked every negedge.
module tb_usb_bus_arb;
`ifdef USB_BUS_ARB_WATCHDOG_EN
  localparam int TO = 4;
`else
  localparam int TO = 63;
`endif
  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] m0_addr, m1_addr, s_addr;
  logic [15:0]   m0_din, m1_din, m0_dout, m1_dout, s_din, s_dout;
  logic          m0_cyc, m1_cyc, m0_we, m1_we, m0_ack, m1_ack, m0_err, m1_err;
  logic          s_cyc, s_we, s_ack;
  logic [1:0]    grant;

  usb_bus_arb #(.TIMEOUT(TO), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_addr(m0_addr), .m0_din(m0_din), .m0_dout(m0_dout), .m0_cyc(m0_cyc),
    .m0_we(m0_we), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_din(m1_din), .m1_dout(m1_dout), .m1_cyc(m1_cyc),
    .m1_we(m1_we), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .s_cyc(s_cyc),
    .s_we(s_we), .s_ack(s_ack), .grant(grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  who;
    logic [15:0] dout;
    logic        err;
  } sb_t;

  sb_t sb_q[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic expect_ack(input logic [1:0] who, input logic [15:0] d, input logic err);
    sb_t e;
    e.who  = who;
    e.dout = d;
    e.err  = err;
    sb_q.push_back(e);
  endtask

  task automatic do_ack(input logic [1:0] who, input logic [15:0] d);
    s_ack  = 1'b1;
    s_dout = d;
    expect_ack(who, d, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Every expected completion is pushed in the cycle it must appear; anything else is unexpected.
  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check("sb_ack", {30'd0, m1_ack, m0_ack}, {30'd0, e.who});
      check("sb_dout", e.who[1] ? {16'd0, m1_dout} : {16'd0, m0_dout}, {16'd0, e.dout});
      check("sb_dout_other", e.who[1] ? {16'd0, m0_dout} : {16'd0, m1_dout}, 32'd0);
      check("sb_err", {31'd0, m0_err | m1_err}, {31'd0, e.err});
    end else if (m0_ack || m1_ack || m0_err || m1_err) begin
      check("sb_unexpected", {28'd0, m1_err, m0_err, m1_ack, m0_ack}, 32'd0);
    end
  end

  initial begin
    rst = 1'b1; s_ack = 1'b0; s_dout = '0;
    m0_addr = '0; m0_din = '0; m0_cyc = 1'b1; m0_we = 1'b0;
    m1_addr = '0; m1_din = '0; m1_cyc = 1'b0; m1_we = 1'b0;

    // Reset held with a request pending
    repeat (3) begin
      step(); settle();
      check("rst_scyc", {31'd0, s_cyc}, 0);
      check("rst_grant", {30'd0, grant}, 0);
    end
    step(); rst = 1'b0; settle();
    check("post_rst_scyc", {31'd0, s_cyc}, 0);
    check("post_rst_grant", {30'd0, grant}, 0);

    // m0 read of 0x000, slave acks two cycles after s_cyc
    step(); settle();
    check("t1_grant", {30'd0, grant}, 32'h1);
    check("t1_scyc", {31'd0, s_cyc}, 1);
    check("t1_saddr", {20'd0, s_addr}, 32'h000);
    check("t1_swe", {31'd0, s_we}, 0);
    step(); settle();
    check("t1_wait_ack", {31'd0, m0_ack}, 0);
    step(); do_ack(2'b01, 16'h8012); settle();
    check("t1_m1_ack", {31'd0, m1_ack}, 0);
    step(); s_ack = 1'b0; m0_addr = 12'h055; m0_we = 1'b1; m0_din = 16'h1111; settle();
    check("t1_gap_scyc", {31'd0, s_cyc}, 0);
    check("t1_gap_grant", {30'd0, grant}, 0);
    step(); settle();
    check("t1_idle_scyc", {31'd0, s_cyc}, 0);
    step(); settle();
    check("t1_wr_scyc", {31'd0, s_cyc}, 1);
    check("t1_wr_addr", {20'd0, s_addr}, 32'h055);
    check("t1_wr_we", {31'd0, s_we}, 1);
    check("t1_wr_din", {16'd0, s_din}, 32'h1111);
    do_ack(2'b01, 16'hBEEF);
    // s_ack in GAP and IDLE must be ignored
    step(); s_ack = 1'b1; s_dout = 16'hFFFF; m0_cyc = 1'b0; m0_we = 1'b0; settle();
    check("t1_gap_ignore", {31'd0, m0_ack}, 0);
    step(); settle();
    check("t1_idle_ignore", {30'd0, m1_ack, m0_ack}, 0);
    step(); s_ack = 1'b0;

    // Contention right after reset: m0, then m1, then m0 again
    do_reset();
    m0_cyc = 1'b1; m0_addr = 12'h0A0; m1_cyc = 1'b1; m1_addr = 12'h0B1; settle();
    check("t2_idle_grant", {30'd0, grant}, 0);
    step(); settle();
    check("t2_first", {30'd0, grant}, 32'h1);
    check("t2_first_addr", {20'd0, s_addr}, 32'h0A0);
    do_ack(2'b01, 16'h0001);
    step(); s_ack = 1'b0; m0_cyc = 1'b0; settle();
    check("t2_gap_grant", {30'd0, grant}, 0);
    step(); settle();
    check("t2_idle_grant2", {30'd0, grant}, 0);
    step(); settle();
    check("t2_second", {30'd0, grant}, 32'h2);
    check("t2_second_addr", {20'd0, s_addr}, 32'h0B1);
    do_ack(2'b10, 16'h0002);
    step(); s_ack = 1'b0; m0_cyc = 1'b1;
    step();
    step(); settle();
    check("t2_alt_m0", {30'd0, grant}, 32'h1);
    do_ack(2'b01, 16'h0003);
    step(); s_ack = 1'b0; m0_cyc = 1'b0;
    step();
    step(); settle();
    check("t2_alt_m1", {30'd0, grant}, 32'h2);
    do_ack(2'b10, 16'h0004);
    step(); s_ack = 1'b0; m1_cyc = 1'b0;
    step();

    // m1 write holds the bus while m0 waits
    m1_cyc = 1'b1; m1_we = 1'b1; m1_addr = 12'h800; m1_din = 16'h00C3;
    step(); settle();
    m0_cyc = 1'b1; m0_addr = 12'h3FF; m0_din = 16'hAAAA; m0_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      settle();
      check("t3_addr", {20'd0, s_addr}, 32'h800);
      check("t3_din", {16'd0, s_din}, 32'h00C3);
      check("t3_we", {31'd0, s_we}, 1);
      check("t3_grant", {30'd0, grant}, 32'h2);
      if (i < 2) step();
    end
    do_ack(2'b10, 16'h5A5A); settle();
    check("t3_ack_addr", {20'd0, s_addr}, 32'h800);
    step(); s_ack = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0;
    step();
    step(); settle();
    check("t3_m0_grant", {30'd0, grant}, 32'h1);
    check("t3_m0_addr", {20'd0, s_addr}, 32'h3FF);
    do_ack(2'b01, 16'h0C0C);
    step(); s_ack = 1'b0; m0_cyc = 1'b0;
    step();

    // m0 aborts while m1 is pending
    m0_cyc = 1'b1; m0_addr = 12'h111;
    step(); settle();
    check("t4_grant", {30'd0, grant}, 32'h1);
    m1_cyc = 1'b1; m1_addr = 12'h222;
    step(); m0_cyc = 1'b0; settle();
    check("t4_abort_scyc", {31'd0, s_cyc}, 0);
    check("t4_abort_ack", {31'd0, m0_ack}, 0);
    step(); settle();
    check("t4_gap_grant", {30'd0, grant}, 0);
    step(); settle();
    check("t4_idle_grant", {30'd0, grant}, 0);
    step(); settle();
    check("t4_m1_grant", {30'd0, grant}, 32'h2);
    check("t4_m1_addr", {20'd0, s_addr}, 32'h222);
    do_ack(2'b10, 16'h2222);
    step(); s_ack = 1'b0; m1_cyc = 1'b0;
    step();

    // Reset pulse during OWN1 with a simultaneous slave ack
    m1_cyc = 1'b1; m1_addr = 12'h333;
    step(); settle();
    check("t5_own1", {30'd0, grant}, 32'h2);
    step(); rst = 1'b1; s_ack = 1'b1; s_dout = 16'h7777; settle();
    check("t5_rst_scyc", {31'd0, s_cyc}, 0);
    check("t5_rst_grant", {30'd0, grant}, 0);
    check("t5_rst_ack", {31'd0, m1_ack}, 0);
    step(); rst = 1'b0; s_ack = 1'b0; m0_cyc = 1'b1; m0_addr = 12'h444; settle();
    check("t5_post_scyc", {31'd0, s_cyc}, 0);
    check("t5_post_grant", {30'd0, grant}, 0);
    step(); settle();
    check("t5_m0_wins", {30'd0, grant}, 32'h1);
    do_ack(2'b01, 16'h4444);
    step(); s_ack = 1'b0; m0_cyc = 1'b0;
    step();
    step(); settle();
    check("t5_m1_next", {30'd0, grant}, 32'h2);
    do_ack(2'b10, 16'h3333);
    step(); s_ack = 1'b0; m1_cyc = 1'b0;
    step();

    // Silent slave
    m0_cyc = 1'b1; m0_addr = 12'h555; s_dout = 16'hDEAD;
    step();
`ifdef USB_BUS_ARB_WATCHDOG_EN
    for (int i = 0; i < TO; i++) begin
      settle();
      check("t6_wd_grant", {30'd0, grant}, 32'h1);
      if (i == TO - 1) expect_ack(2'b01, 16'h0000, 1'b1);
      step();
    end
    settle();
    check("t6_wd_gap_scyc", {31'd0, s_cyc}, 0);
    check("t6_wd_gap_grant", {30'd0, grant}, 0);
    m0_cyc = 1'b0;
    step();
    m0_cyc = 1'b1;
    step();
    for (int i = 0; i < TO; i++) begin
      settle();
      if (i == TO - 1) do_ack(2'b01, 16'h6666);
      step();
    end
    s_ack = 1'b0; m0_cyc = 1'b0;
    step();
`else
    for (int i = 0; i < 70; i++) begin
      settle();
      check("t6_hold_grant", {30'd0, grant}, 32'h1);
      check("t6_hold_scyc", {31'd0, s_cyc}, 1);
      check("t6_hold_err", {31'd0, m0_err}, 0);
      step();
    end
    do_ack(2'b01, 16'h5555);
    step(); s_ack = 1'b0; m0_cyc = 1'b0;
    step();
`endif

    step(); step();
    check("sb_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
